rom_load_sequencer: RTL and testbench

Upstream write controller for the team's 32x8 storage block (the memory driven by D, A, Clear, Load). It accepts a byte stream over a valid/ready handshake, issues one Load per byte to consecutive addresses starting at 0, and on request performs a full clear sweep by pulsing Clear across every address. All memory-side outputs are registered so they connect directly to the storage block's D/A/Clear/Load inputs.

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_load_sequencer_if.sv | 27 ++
 rtl/rom_addr_ctr.sv | 23 ++
 rtl/rom_load_sequencer.sv | 131 +++++++++++++
 tb/tb_rom_load_sequencer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/rom_pkg.sv
// Shared constants and FSM state type for the ROM load sequencer and its counters.
package rom_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/rom_load_sequencer_if.sv
// Byte-stream handshake plus storage-block write/clear bus for rom_load_sequencer.
interface rom_load_sequencer_if;
  import rom_pkg::*;

  logic              In_valid;
  logic [DATA_W-1:0] In_data;
  logic              In_ready;
  logic              Clear_all;
  logic [DATA_W-1:0] D;
  logic [ADDR_W-1:0] A;
  logic              Load;
  logic              Clear;
  logic              Busy;
  logic              Full;
  logic [CNT_W-1:0]  Count;

  modport master (
    output In_valid, In_data, Clear_all,
    input  In_ready, D, A, Load, Clear, Busy, Full, Count
  );

  modport slave (
    input  In_valid, In_data, Clear_all,
    output In_ready, D, A, Load, Clear, Busy, Full, Count
  );

endinterface

// File: rtl/rom_addr_ctr.sv
// Address counter with synchronous clear, enable, natural wrap and terminal-count flag.
module rom_addr_ctr
  import rom_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= q + 1'b1;
  end

  assign tc = &q;

endmodule

// File: rtl/rom_load_sequencer.sv
// Write/clear sequencer for the 32x8 storage block; all memory-side outputs registered.
// Optional build macro ROM_LOAD_WRAP_EN: write pointer wraps and overwrites instead of stopping at Full.
module rom_load_sequencer
  import rom_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  rom_load_sequencer_if.slave  bus
);

  state_t            state, state_next;
  logic              handshake;
  logic              sweep_done;
  logic [ADDR_W-1:0] wr_ptr, sweep_ptr;
  logic              wr_last, sweep_last;

  logic [DATA_W-1:0] d_q, d_next;
  logic [ADDR_W-1:0] a_q, a_next;
  logic              load_q, load_next;
  logic              clear_q, clear_next;
  logic              busy_q, busy_next;
  logic              full_q, full_set;
  logic [CNT_W-1:0]  count_q, count_inc;
  logic              in_ready;

`ifdef ROM_LOAD_WRAP_EN
  assign in_ready  = (state == IDLE) && !bus.Clear_all;
  assign count_inc = count_q[ADDR_W] ? count_q : count_q + 1'b1;
  assign full_set  = 1'b0;
`else
  assign in_ready  = (state == IDLE) && !full_q && !bus.Clear_all;
  assign count_inc = count_q + 1'b1;
  assign full_set  = wr_last;
`endif

  assign handshake  = bus.In_valid && in_ready;
  assign sweep_done = (state == SWEEP) && sweep_last;

  rom_addr_ctr #(.W(ADDR_W)) u_wr_ctr (
    .clk (Clk),
    .rst (Reset),
    .clr (sweep_done),
    .en  (handshake),
    .q   (wr_ptr),
    .tc  (wr_last)
  );

  // sweep_ptr tracks the address currently shown on A while sweeping.
  rom_addr_ctr #(.W(ADDR_W)) u_sweep_ctr (
    .clk (Clk),
    .rst (Reset),
    .clr (state == IDLE),
    .en  (state == SWEEP),
    .q   (sweep_ptr),
    .tc  (sweep_last)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    d_next     = d_q;
    a_next     = a_q;
    load_next  = 1'b0;
    clear_next = 1'b0;
    busy_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Clear_all) begin
          state_next = SWEEP;
          d_next     = '0;
          a_next     = '0;
          clear_next = 1'b1;
          busy_next  = 1'b1;
        end else if (handshake) begin
          d_next    = bus.In_data;
          a_next    = wr_ptr;
          load_next = 1'b1;
        end
      end
      SWEEP: begin
        d_next = '0;
        if (sweep_last) begin
          state_next = IDLE;
        end else begin
          a_next     = sweep_ptr + 1'b1;
          clear_next = 1'b1;
          busy_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      d_q     <= '0;
      a_q     <= '0;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      d_q     <= d_next;
      a_q     <= a_next;
      load_q  <= load_next;
      clear_q <= clear_next;
      busy_q  <= busy_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || sweep_done) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (handshake) begin
      count_q <= count_inc;
      full_q  <= full_set;
    end
  end

  assign bus.In_ready = in_ready;
  assign bus.D        = d_q;
  assign bus.A        = a_q;
  assign bus.Load     = load_q;
  assign bus.Clear    = clear_q;
  assign bus.Busy     = busy_q;
  assign bus.Full     = full_q;
  assign bus.Count    = count_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer: vector table plus hand-written fill, sweep and reset sequences.
module tb_rom_load_sequencer;
  import rom_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  logic rdy_s;
  int   errors = 0;
  int   checks = 0;

`ifdef ROM_LOAD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  rom_load_sequencer_if bus ();

  rom_load_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    logic       rdy;
    logic       load;
    logic       clr;
    logic [4:0] a;
    logic [7:0] dout;
    logic       busy;
    logic       full;
    logic [5:0] cnt;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, capture the combinational ready, then step past the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic c);
    bus.In_valid  = v;
    bus.In_data   = d;
    bus.Clear_all = c;
    #1;
    rdy_s = bus.In_ready;
    @(posedge Clk);
    #1;
    check("load_clear_excl", {31'd0, bus.Load & bus.Clear}, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic load, input logic clr,
                            input logic [4:0] a, input logic [7:0] d, input logic busy,
                            input logic full, input logic [5:0] cnt);
    check({tag, ".load"},  {31'd0, bus.Load},  {31'd0, load});
    check({tag, ".clear"}, {31'd0, bus.Clear}, {31'd0, clr});
    check({tag, ".a"},     {27'd0, bus.A},     {27'd0, a});
    check({tag, ".d"},     {24'd0, bus.D},     {24'd0, d});
    check({tag, ".busy"},  {31'd0, bus.Busy},  {31'd0, busy});
    check({tag, ".full"},  {31'd0, bus.Full},  {31'd0, full});
    check({tag, ".count"}, {26'd0, bus.Count}, {26'd0, cnt});
  endtask

  // Remaining sweep after the entry cycle (A=0 already shown), then the return to IDLE.
  task automatic sweep_tail(input logic [5:0] cnt, input logic full);
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      check("sweep.rdy", {31'd0, rdy_s}, 32'd0);
      expect_out($sformatf("sweep%0d", i), 1'b0, 1'b1, 5'(i), 8'h00, 1'b1, full, cnt);
    end
    cycle(1'b0, 8'h00, 1'b0);
    check("sweep_end.rdy", {31'd0, rdy_s}, 32'd0);
    check("sweep_end.clear", {31'd0, bus.Clear}, 32'd0);
    check("sweep_end.busy", {31'd0, bus.Busy}, 32'd0);
    check("sweep_end.count", {26'd0, bus.Count}, 32'd0);
    check("sweep_end.full", {31'd0, bus.Full}, 32'd0);
    check("sweep_end.in_ready", {31'd0, bus.In_ready}, 32'd1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h66, 1'b0, 1'b0, 6'd1};
    tbl[1] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 8'hC3, 1'b0, 1'b0, 6'd2};
    tbl[2] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 8'hC3, 1'b0, 1'b0, 6'd2};
    tbl[3] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 1'b1, 1'b0, 6'd2};

    bus.In_valid  = 1'b0;
    bus.In_data   = 8'h00;
    bus.Clear_all = 1'b0;

    // Reset state
    do_reset();
    expect_out("reset", 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 6'd0);
    check("reset.in_ready", {31'd0, bus.In_ready}, 32'd1);

    // Two writes, an idle cycle, then Clear_all colliding with In_valid
    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("vec%0d.rdy", i), {31'd0, rdy_s}, {31'd0, tbl[i].rdy});
      expect_out($sformatf("vec%0d", i), tbl[i].load, tbl[i].clr, tbl[i].a, tbl[i].dout,
                 tbl[i].busy, tbl[i].full, tbl[i].cnt);
    end
    sweep_tail(6'd2, 1'b0);
    cycle(1'b1, 8'h7E, 1'b0);
    check("after_sweep.rdy", {31'd0, rdy_s}, 32'd1);
    expect_out("after_sweep", 1'b1, 1'b0, 5'd0, 8'h7E, 1'b0, 1'b0, 6'd1);

    // Back-to-back fill of every address
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      check($sformatf("fill%0d.rdy", i), {31'd0, rdy_s}, 32'd1);
      expect_out($sformatf("fill%0d", i), 1'b1, 1'b0, 5'(i), 8'(i), 1'b0,
                 (i == DEPTH - 1) && !WRAP, 6'(i + 1));
    end
    cycle(1'b1, 8'hAA, 1'b0);
    if (WRAP) begin
      check("byte33.rdy", {31'd0, rdy_s}, 32'd1);
      expect_out("byte33", 1'b1, 1'b0, 5'd0, 8'hAA, 1'b0, 1'b0, 6'd32);
    end else begin
      check("byte33.rdy", {31'd0, rdy_s}, 32'd0);
      expect_out("byte33", 1'b0, 1'b0, 5'd31, 8'h1F, 1'b0, 1'b1, 6'd32);
    end

    // Clear_all pulse after the fill
    cycle(1'b0, 8'h00, 1'b1);
    check("clr_pulse.rdy", {31'd0, rdy_s}, 32'd0);
    expect_out("clr_entry", 1'b0, 1'b1, 5'd0, 8'h00, 1'b1, !WRAP, 6'd32);
    sweep_tail(6'd32, !WRAP);

    // Reset landing while address 10 is being cleared
    cycle(1'b1, 8'h5A, 1'b0);
    expect_out("pre_abort", 1'b1, 1'b0, 5'd0, 8'h5A, 1'b0, 1'b0, 6'd1);
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 10; i++) cycle(1'b0, 8'h00, 1'b0);
    expect_out("at_addr10", 1'b0, 1'b1, 5'd10, 8'h00, 1'b1, 1'b0, 6'd1);
    Reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    Reset = 1'b0;
    expect_out("abort", 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 6'd0);
    check("abort.in_ready", {31'd0, bus.In_ready}, 32'd1);
    cycle(1'b1, 8'h11, 1'b0);
    expect_out("post_abort", 1'b1, 1'b0, 5'd0, 8'h11, 1'b0, 1'b0, 6'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
